// File: rtl/ibex_rf_wport_arbiter.sv
// Register-file write-port arbiter.
// The single RF write port is shared between LSU load data, the writeback
// result and a buffered coprocessor result. LSU has the highest priority,
// then writeback, then the coprocessor result.
// Coprocessor results wait in a 1-entry skid buffer until the port is free.
// A per-register scoreboard marks destinations of coprocessor instructions
// that have been issued but not yet retired.
// A starvation counter asks ID/EX to stall issue when the buffered result
// has been blocked for too long.
module ibex_rf_wport_arbiter #(
    parameter int MaxStallCycles = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_waddr_i,
    input  logic [31:0] wb_wdata_i,
    input  logic        lsu_we_i,
    input  logic [4:0]  lsu_waddr_i,
    input  logic [31:0] lsu_wdata_i,
    input  logic        cop_issue_i,
    input  logic [4:0]  cop_issue_waddr_i,
    input  logic        cop_valid_i,
    output logic        cop_ready_o,
    input  logic        cop_we_i,
    input  logic [4:0]  cop_waddr_i,
    input  logic [31:0] cop_wdata_i,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic [31:0] rf_pending_o,
    output logic        id_stall_o,
    output logic        err_o
);

    localparam logic [3:0] MaxCnt = 4'(MaxStallCycles);

    // Skid buffer: control state is reset, payload is not.
    logic        skid_valid_q, skid_valid_d;
    logic        skid_we_q;
    logic [4:0]  skid_waddr_q;
    logic [31:0] skid_wdata_q;

    logic [31:0] pending_q, pending_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        stall_q;
    logic        err_q, err_d;

    logic        grant_skid;
    logic        cop_accept;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;
    logic        issue_conflict;

    // The skid entry only reaches the port when neither LSU nor WB is writing.
    assign grant_skid  = skid_valid_q & ~lsu_we_i & ~wb_we_i;
    // A draining entry frees the buffer in the same cycle, so a new result can be taken.
    assign cop_ready_o = ~skid_valid_q | grant_skid;
    assign cop_accept  = cop_valid_i & cop_ready_o;

    // Write-port mux; the address and data outputs are forced to zero when no write occurs.
    always_comb begin
        rf_we_o    = 1'b0;
        rf_waddr_o = 5'd0;
        rf_wdata_o = 32'd0;
        if (lsu_we_i) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = lsu_waddr_i;
            rf_wdata_o = lsu_wdata_i;
        end else if (wb_we_i) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = wb_waddr_i;
            rf_wdata_o = wb_wdata_i;
        end else if (grant_skid && skid_we_q) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = skid_waddr_q;
            rf_wdata_o = skid_wdata_q;
        end
    end

    // Scoreboard update: set on issue (never x0), clear on drain, set wins on a collision.
    always_comb begin
        set_mask = 32'd0;
        clr_mask = 32'd0;
        if (cop_issue_i && (cop_issue_waddr_i != 5'd0)) begin
            set_mask[cop_issue_waddr_i] = 1'b1;
        end
        if (grant_skid) begin
            clr_mask[skid_waddr_q] = 1'b1;
        end
        pending_d      = (pending_q & ~clr_mask) | set_mask;
        issue_conflict = cop_issue_i && (cop_issue_waddr_i != 5'd0) &&
                         pending_q[cop_issue_waddr_i] && !clr_mask[cop_issue_waddr_i];
    end

    // Next-state for the skid valid flag, starvation counter and sticky error.
    always_comb begin
        skid_valid_d = skid_valid_q;
        if (cop_accept) begin
            skid_valid_d = 1'b1;
        end else if (grant_skid) begin
            skid_valid_d = 1'b0;
        end

        cnt_d = cnt_q;
        if (grant_skid) begin
            cnt_d = 4'd0;
        end else if (skid_valid_q && (cnt_q < MaxCnt)) begin
            cnt_d = cnt_q + 4'd1;
        end

        err_d = err_q | (wb_we_i & lsu_we_i) | issue_conflict;
    end

    // Control state with asynchronous reset; the stall flag is registered from cnt_d.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            skid_valid_q <= 1'b0;
            pending_q    <= 32'd0;
            cnt_q        <= 4'd0;
            stall_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            skid_valid_q <= skid_valid_d;
            pending_q    <= pending_d;
            cnt_q        <= cnt_d;
            stall_q      <= (cnt_d == MaxCnt);
            err_q        <= err_d;
        end
    end

    // Skid payload captured on every accepted coprocessor result.
    always_ff @(posedge clk_i) begin
        if (cop_accept) begin
            skid_we_q    <= cop_we_i;
            skid_waddr_q <= cop_waddr_i;
            skid_wdata_q <= cop_wdata_i;
        end
    end

    assign rf_pending_o = pending_q;
    assign id_stall_o   = stall_q;
    assign err_o        = err_q;

endmodule
